if_bp_fetch: RTL and testbench
==============================

Name: if_bp_fetch

Overview:
- Parameterised instruction-fetch (IF) stage for the 5-stage MIPS pipeline.
- Replaces the static PC+4 / ID-resolved PC mux with a direct-mapped branch target buffer (BTB) and 2-bit saturating predictors.
- Predicts the next PC in IF; ID-stage branch/jump resolution returns through an update/redirect port.
- Keeps a saturating mispredict counter for the debug bus.

Parameters:
- ADDR_W, 32: PC / target width in bits.
- ENTRIES, 16: BTB entries; power of 2, 2..256.
- RESET_PC, 0: PC value loaded on reset.
- PRED_EN, 1: 1 = BTB prediction active; 0 = always predict not-taken and never write the BTB (legacy mode).
- CNT_W, 16: mispredict counter width.

Ports:
- clk  in  1  main clock
- rst  in  1  asynchronous active-high reset
- en  in  1  stage enable; 0 = stall, PC holds
- inst_ren  out  1  instruction read enable
- inst_addr  out  ADDR_W  current fetch PC
- pred_taken  out  1  BTB predicts taken for inst_addr
- pred_next_pc  out  ADDR_W  predicted next PC (travels down the pipe with the instruction)
- res_valid  in  1  ID stage presents a resolved instruction this cycle
- res_pc  in  ADDR_W  PC of the resolved instruction
- res_is_branch  in  1  resolved instruction is a branch or jump
- res_taken  in  1  actual direction
- res_target  in  ADDR_W  actual taken target
- res_mispredict  in  1  ID detected that its carried pred_next_pc != actual next PC
- mispredict_cnt  out  CNT_W  saturating count of mispredicts

Behaviour:
- Reset:
  - Asynchronous, active-high; single clock clk.
  - While rst=1: inst_addr=RESET_PC, inst_ren=0, mispredict_cnt=0.
  - All BTB valid bits cleared; all counters set to 2'b01.
  - pred_taken=0; pred_next_pc=RESET_PC+4.
  - rst asserted mid-operation discards any pending update in that cycle.
- inst_ren = ~rst, combinational.
- Index and tag:
  - IDX_W = log2(ENTRIES).
  - index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2].
  - pc[1:0] is ignored.
- Lookup (combinational on inst_addr):
  - hit = valid[index] & tag match.
  - pred_taken = PRED_EN & hit & ctr[index][1].
  - pred_next_pc = pred_taken ? target[index] : inst_addr+4.
  - Adders are ADDR_W wide and wrap modulo 2^ADDR_W.
- PC update at posedge clk, priority order:
  1. res_valid & res_mispredict: inst_addr <= res_taken ? res_target : res_pc+4. Applied even when en=0. mispredict_cnt increments, saturating at all-ones.
  2. else if en: inst_addr <= pred_next_pc.
  3. else hold.
- BTB update at posedge clk, only when PRED_EN=1 and res_valid=1. Looked up at res_pc.
  - res_is_branch & hit:
    - ctr increments if res_taken, otherwise decrements; saturates at 3 and 0.
    - If res_taken, target <= res_target.
  - res_is_branch & miss & res_taken: allocate (overwrite) the entry: valid=1, tag=tag(res_pc), target=res_target, ctr=2'b10.
  - res_is_branch & miss & ~res_taken: no change.
  - ~res_is_branch & hit (alias entry): valid <= 0.
  - BTB update is independent of en; a stalled pipe still trains.
- Same-index lookup and update in one cycle: the lookup sees the pre-update contents. Write-then-read becomes visible on the next cycle.
- res_mispredict with res_valid=0 is ignored.
- Latency:
  - Prediction: 0 cycles (combinational on inst_addr).
  - Redirect: 1 cycle; inst_addr shows the corrected PC after the edge.
  - Counter training: visible to a lookup on the following cycle.
- PRED_EN=0: pred_taken is constant 0, BTB state stays at reset values, redirect and counter behaviour unchanged. Functionally equals the PC_NEXT / branch-in-ID scheme.

Test Plan:
- Reset, then en=1 for 4 cycles -> inst_addr 0x0, 0x4, 0x8, 0xC; pred_taken=0; mispredict_cnt=0.
- Resolve res_pc=0x10, is_branch=1, taken=1, target=0x40, mispredict=1 -> next inst_addr=0x40, mispredict_cnt=1. Later fetch of 0x10 -> pred_taken=1, pred_next_pc=0x40.
- Train 0x10 not-taken twice from ctr=2'b10 -> ctr reaches 0. Fetch 0x10 -> pred_taken=0, pred_next_pc=0x14. A third not-taken keeps ctr=0.
- Aliasing, ENTRIES=16: 0x10 allocated, then fetch 0x50 (same index, different tag) -> pred_taken=0. Resolve 0x10 with is_branch=0 -> entry invalidated, fetch 0x10 predicts 0x14.
- Redirect with en=0 -> inst_addr updates anyway. Same-cycle allocate at the current inst_addr index -> pred_taken=0 that cycle, 1 the next.
- PRED_EN=0, repeat scenario 2 -> redirect to 0x40 still occurs, fetch 0x10 gives pred_taken=0. mispredict_cnt with CNT_W=2 driven with 5 mispredicts -> saturates at 3.

Source files
------------

// File: rtl/if_bp_fetch.sv
// Instruction-fetch stage: the next PC is predicted from a direct-mapped BTB with 2-bit counters.
// Instructions resolved in ID train the BTB and redirect the PC when a prediction was wrong.
module if_bp_fetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       ENTRIES  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PRED_EN  = 1,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              inst_ren,
    output logic [ADDR_W-1:0] inst_addr,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_next_pc,
    input  logic              res_valid,
    input  logic [ADDR_W-1:0] res_pc,
    input  logic              res_is_branch,
    input  logic              res_taken,
    input  logic [ADDR_W-1:0] res_target,
    input  logic              res_mispredict,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic [IDX_W-1:0] f_idx, r_idx;
    logic [TAG_W-1:0] f_tag, r_tag;
    logic             f_hit, r_hit;
    logic [1:0]       r_ctr_nxt;
    logic             upd_ctr, upd_tgt, alloc, inval;

    assign inst_ren = ~rst;

    // Fetch-side lookup; a same-cycle training write is not visible until the next cycle.
    assign f_idx        = inst_addr[IDX_W+1:2];
    assign f_tag        = inst_addr[ADDR_W-1:IDX_W+2];
    assign f_hit        = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken   = (PRED_EN != 0) && f_hit && ctr_q[f_idx][1];
    assign pred_next_pc = pred_taken ? target_q[f_idx] : inst_addr + ADDR_W'(4);

    assign r_idx = res_pc[IDX_W+1:2];
    assign r_tag = res_pc[ADDR_W-1:IDX_W+2];
    assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

    always_comb begin
        r_ctr_nxt = ctr_q[r_idx];
        if (res_taken) begin
            if (r_ctr_nxt != 2'b11) r_ctr_nxt = r_ctr_nxt + 2'b01;
        end else begin
            if (r_ctr_nxt != 2'b00) r_ctr_nxt = r_ctr_nxt - 2'b01;
        end
    end

    always_comb begin
        upd_ctr = 1'b0;
        upd_tgt = 1'b0;
        alloc   = 1'b0;
        inval   = 1'b0;
        if ((PRED_EN != 0) && res_valid) begin
            if (res_is_branch) begin
                upd_ctr = r_hit;
                upd_tgt = r_hit && res_taken;
                alloc   = !r_hit && res_taken;
            end else begin
                inval = r_hit;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_addr      <= RESET_PC;
            mispredict_cnt <= '0;
        end else if (res_valid && res_mispredict) begin
            inst_addr <= res_taken ? res_target : res_pc + ADDR_W'(4);
            if (mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
        end else if (en) begin
            inst_addr <= pred_next_pc;
        end
    end

    // Training ignores en so a stalled front end still learns from ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            if (upd_ctr) ctr_q[r_idx] <= r_ctr_nxt;
            if (upd_tgt) target_q[r_idx] <= res_target;
            if (alloc) begin
                valid_q[r_idx]  <= 1'b1;
                tag_q[r_idx]    <= r_tag;
                target_q[r_idx] <= res_target;
                ctr_q[r_idx]    <= 2'b10;
            end
            if (inval) valid_q[r_idx] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_bp_fetch.sv
// Bench for if_bp_fetch: a predicting instance (16-bit counter) and a legacy instance (2-bit counter)
// share stimulus; directed table vectors plus random traffic against a per-index BTB model.
module tb_if_bp_fetch;

    localparam int NENT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, rv = 1'b0, rbr = 1'b0, rtk = 1'b0, rmis = 1'b0;
    logic [31:0] rpc = '0, rtgt = '0;

    logic        ren0, pt0, ren1, pt1;
    logic [31:0] addr0, pnpc0, addr1, pnpc1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    always #5 clk = ~clk;

    if_bp_fetch #(.ADDR_W(32), .ENTRIES(16), .RESET_PC(32'h0), .PRED_EN(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .en(en), .inst_ren(ren0), .inst_addr(addr0),
        .pred_taken(pt0), .pred_next_pc(pnpc0), .res_valid(rv), .res_pc(rpc),
        .res_is_branch(rbr), .res_taken(rtk), .res_target(rtgt),
        .res_mispredict(rmis), .mispredict_cnt(cnt0)
    );

    if_bp_fetch #(.ADDR_W(32), .ENTRIES(16), .RESET_PC(32'h0), .PRED_EN(0), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .en(en), .inst_ren(ren1), .inst_addr(addr1),
        .pred_taken(pt1), .pred_next_pc(pnpc1), .res_valid(rv), .res_pc(rpc),
        .res_is_branch(rbr), .res_taken(rtk), .res_target(rtgt),
        .res_mispredict(rmis), .mispredict_cnt(cnt1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one record per BTB slot, indices/tags derived by division.
    typedef struct packed {
        logic        v;
        logic [31:0] tag;
        logic [31:0] tgt;
        logic [1:0]  c;
    } ent_t;

    ent_t        btb [2][NENT];
    logic [31:0] m_pc [2];
    int unsigned m_cnt [2];

    function automatic int unsigned cnt_max(input int k);
        return (k == 0) ? 65535 : 3;
    endfunction

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % NENT;
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (4 * NENT);
    endfunction

    function automatic logic m_pt(input int k);
        ent_t e;
        e = btb[k][idx_of(m_pc[k])];
        return (k == 0) && e.v && (e.tag == tag_of(m_pc[k])) && (e.c >= 2);
    endfunction

    function automatic logic [31:0] m_pnpc(input int k);
        return m_pt(k) ? btb[k][idx_of(m_pc[k])].tgt : m_pc[k] + 32'd4;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]  = 32'h0;
            m_cnt[k] = 0;
            for (int i = 0; i < NENT; i++) btb[k][i] = '{v: 1'b0, tag: '0, tgt: '0, c: 2'd1};
        end
    endtask

    task automatic model_step();
        logic [31:0] nxt;
        int unsigned i;
        logic hit;
        for (int k = 0; k < 2; k++) begin
            if (rv && rmis) begin
                nxt = rtk ? rtgt : rpc + 32'd4;
                if (m_cnt[k] < cnt_max(k)) m_cnt[k]++;
            end else if (en) begin
                nxt = m_pnpc(k);
            end else begin
                nxt = m_pc[k];
            end
            if (k == 0 && rv) begin
                i   = idx_of(rpc);
                hit = btb[k][i].v && (btb[k][i].tag == tag_of(rpc));
                if (rbr) begin
                    if (hit) begin
                        if (rtk) begin
                            if (btb[k][i].c != 2'd3) btb[k][i].c++;
                            btb[k][i].tgt = rtgt;
                        end else if (btb[k][i].c != 2'd0) begin
                            btb[k][i].c--;
                        end
                    end else if (rtk) begin
                        btb[k][i] = '{v: 1'b1, tag: tag_of(rpc), tgt: rtgt, c: 2'd2};
                    end
                end else if (hit) begin
                    btb[k][i].v = 1'b0;
                end
            end
            m_pc[k] = nxt;
        end
    endtask

    task automatic check_model();
        chk("model ren0", 32'(ren0), 32'(!rst));
        chk("model addr0", addr0, m_pc[0]);
        chk("model pt0", 32'(pt0), 32'(m_pt(0)));
        chk("model pnpc0", pnpc0, m_pnpc(0));
        chk("model cnt0", 32'(cnt0), m_cnt[0]);
        chk("model ren1", 32'(ren1), 32'(!rst));
        chk("model addr1", addr1, m_pc[1]);
        chk("model pt1", 32'(pt1), 32'(m_pt(1)));
        chk("model pnpc1", pnpc1, m_pnpc(1));
        chk("model cnt1", 32'(cnt1), m_cnt[1]);
    endtask

    task automatic drive(input logic r, input logic e, input logic v, input logic [31:0] pc,
                         input logic b, input logic t, input logic [31:0] tg, input logic m);
        @(negedge clk);
        rst = r; en = e; rv = v; rpc = pc; rbr = b; rtk = t; rtgt = tg; rmis = m;
        if (r) model_reset();
        #1;
        check_model();
    endtask

    task automatic edge_update();
        @(posedge clk);
        if (!rst) model_step();
    endtask

    typedef struct packed {
        logic        en, rv;
        logic [31:0] rpc;
        logic        br, tk;
        logic [31:0] tgt;
        logic        mis;
        logic [31:0] a0;
        logic        p0;
        logic [31:0] n0;
        logic [15:0] c0;
        logic [31:0] a1;
        logic [1:0]  c1;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic e, input logic v, input logic [31:0] pc, input logic b,
                                input logic t, input logic [31:0] tg, input logic m,
                                input logic [31:0] a0, input logic p0, input logic [31:0] n0,
                                input logic [15:0] c0, input logic [31:0] a1, input logic [1:0] c1);
        return '{en: e, rv: v, rpc: pc, br: b, tk: t, tgt: tg, mis: m,
                 a0: a0, p0: p0, n0: n0, c0: c0, a1: a1, c1: c1};
    endfunction

    task automatic chk_const(input string tag, input logic [31:0] a0, input logic p0, input logic [31:0] n0,
                             input logic [15:0] c0, input logic [31:0] a1, input logic [1:0] c1);
        chk({tag, " addr0"}, addr0, a0);
        chk({tag, " pt0"}, 32'(pt0), 32'(p0));
        chk({tag, " pnpc0"}, pnpc0, n0);
        chk({tag, " cnt0"}, 32'(cnt0), 32'(c0));
        chk({tag, " addr1"}, addr1, a1);
        chk({tag, " pt1"}, 32'(pt1), 32'h0);
        chk({tag, " pnpc1"}, pnpc1, a1 + 32'd4);
        chk({tag, " cnt1"}, 32'(cnt1), 32'(c1));
    endtask

    logic [31:0] pc_r, tg_r;

    initial begin
        //                 en rv  res_pc       br tk target      mis  addr0        p0 pnpc0     c0  addr1        c1
        vecs.push_back(mk(1, 0, 32'h00,       0, 0, 32'h0,   0, 32'h00,       0, 32'h04, 0, 32'h00,       0));
        vecs.push_back(mk(1, 0, 32'h00,       0, 0, 32'h0,   0, 32'h04,       0, 32'h08, 0, 32'h04,       0));
        vecs.push_back(mk(1, 0, 32'h00,       0, 0, 32'h0,   0, 32'h08,       0, 32'h0C, 0, 32'h08,       0));
        vecs.push_back(mk(1, 1, 32'h10,       1, 1, 32'h40,  1, 32'h0C,       0, 32'h10, 0, 32'h0C,       0));
        vecs.push_back(mk(1, 0, 32'h00,       0, 0, 32'h0,   0, 32'h40,       0, 32'h44, 1, 32'h40,       1));
        vecs.push_back(mk(0, 1, 32'h0C,       0, 0, 32'h0,   1, 32'h44,       0, 32'h48, 1, 32'h44,       1));
        vecs.push_back(mk(0, 0, 32'h00,       0, 0, 32'h0,   0, 32'h10,       1, 32'h40, 2, 32'h10,       2));
        vecs.push_back(mk(0, 1, 32'h10,       1, 0, 32'h0,   0, 32'h10,       1, 32'h40, 2, 32'h10,       2));
        vecs.push_back(mk(0, 1, 32'h10,       1, 0, 32'h0,   0, 32'h10,       0, 32'h14, 2, 32'h10,       2));
        vecs.push_back(mk(0, 1, 32'h10,       1, 0, 32'h0,   0, 32'h10,       0, 32'h14, 2, 32'h10,       2));
        vecs.push_back(mk(0, 1, 32'h10,       1, 1, 32'h80,  0, 32'h10,       0, 32'h14, 2, 32'h10,       2));
        vecs.push_back(mk(0, 1, 32'h10,       1, 1, 32'h80,  0, 32'h10,       0, 32'h14, 2, 32'h10,       2));
        vecs.push_back(mk(1, 0, 32'h00,       0, 0, 32'h0,   0, 32'h10,       1, 32'h80, 2, 32'h10,       2));
        vecs.push_back(mk(0, 1, 32'h00,       1, 1, 32'h50,  1, 32'h80,       0, 32'h84, 2, 32'h14,       2));
        vecs.push_back(mk(0, 0, 32'h00,       0, 0, 32'h0,   0, 32'h50,       0, 32'h54, 3, 32'h50,       3));
        vecs.push_back(mk(0, 1, 32'h10,       0, 0, 32'h0,   0, 32'h50,       0, 32'h54, 3, 32'h50,       3));
        vecs.push_back(mk(0, 1, 32'h0C,       0, 0, 32'h0,   1, 32'h50,       0, 32'h54, 3, 32'h50,       3));
        vecs.push_back(mk(0, 1, 32'h10,       1, 1, 32'h60,  0, 32'h10,       0, 32'h14, 4, 32'h10,       3));
        vecs.push_back(mk(1, 0, 32'h00,       0, 0, 32'h0,   0, 32'h10,       1, 32'h60, 4, 32'h10,       3));
        vecs.push_back(mk(1, 0, 32'h00,       0, 0, 32'h0,   0, 32'h60,       0, 32'h64, 4, 32'h14,       3));
        vecs.push_back(mk(1, 0, 32'h10,       1, 1, 32'h200, 1, 32'h64,       0, 32'h68, 4, 32'h18,       3));
        vecs.push_back(mk(1, 0, 32'h00,       0, 0, 32'h0,   0, 32'h68,       0, 32'h6C, 4, 32'h1C,       3));
        vecs.push_back(mk(0, 1, 32'hFFFFFFF8, 0, 0, 32'h0,   1, 32'h6C,       0, 32'h70, 4, 32'h20,       3));
        vecs.push_back(mk(1, 0, 32'h00,       0, 0, 32'h0,   0, 32'hFFFFFFFC, 0, 32'h00, 5, 32'hFFFFFFFC, 3));
        vecs.push_back(mk(0, 0, 32'h00,       0, 0, 32'h0,   0, 32'h00,       1, 32'h50, 5, 32'h00,       3));

        // Held in reset for two edges.
        for (int n = 0; n < 2; n++) begin
            drive(1, 1, 1, 32'h10, 1, 1, 32'h40, 1);
            chk("reset ren0", 32'(ren0), 32'h0);
            chk("reset ren1", 32'(ren1), 32'h0);
            chk_const("reset", 32'h0, 1'b0, 32'h4, 16'd0, 32'h0, 2'd0);
            edge_update();
        end

        foreach (vecs[i]) begin
            drive(0, vecs[i].en, vecs[i].rv, vecs[i].rpc, vecs[i].br, vecs[i].tk, vecs[i].tgt, vecs[i].mis);
            chk_const($sformatf("vec%0d", i), vecs[i].a0, vecs[i].p0, vecs[i].n0, vecs[i].c0,
                      vecs[i].a1, vecs[i].c1);
            edge_update();
        end

        // Reset landing on a pending redirect + allocate: both must be dropped.
        drive(1, 1, 1, 32'h0, 1, 1, 32'h40, 1);
        chk_const("midrst", 32'h0, 1'b0, 32'h4, 16'd0, 32'h0, 2'd0);
        edge_update();
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        chk("postrst ren0", 32'(ren0), 32'h1);
        chk_const("postrst", 32'h0, 1'b0, 32'h4, 16'd0, 32'h0, 2'd0);
        edge_update();

        for (int n = 0; n < 800; n++) begin
            pc_r = ($urandom_range(0, 7) == 0) ? $urandom : 32'(4 * $urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) pc_r = m_pc[0];
            tg_r = ($urandom_range(0, 7) == 0) ? $urandom : 32'(4 * $urandom_range(0, 63));
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  pc_r, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), tg_r,
                  ($urandom_range(0, 3) == 0));
            edge_update();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
